// File: rtl/sequence_multiplier_pkg.sv
// rtl/sequence_multiplier_pkg.sv - shared gate codes, fixed-point constants, gate table and FSM states
package sequence_multiplier_pkg;

  localparam int SEQ_INDEX_BITS = 6;
  localparam int GATE_BITS      = 5;
  localparam int INT_BITS       = 2;

  localparam logic [GATE_BITS-1:0] GATE_I       = 5'd0;
  localparam logic [GATE_BITS-1:0] GATE_X       = 5'd1;
  localparam logic [GATE_BITS-1:0] GATE_Y       = 5'd2;
  localparam logic [GATE_BITS-1:0] GATE_Z       = 5'd3;
  localparam logic [GATE_BITS-1:0] GATE_H       = 5'd4;
  localparam logic [GATE_BITS-1:0] GATE_S       = 5'd5;
  localparam logic [GATE_BITS-1:0] GATE_T       = 5'd6;
  localparam logic [GATE_BITS-1:0] GATE_FULL    = 5'd7;
  localparam logic [GATE_BITS-1:0] HIGHEST_GATE = GATE_FULL;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_MULT,
    ST_WRITE
  } mult_state_e;

  function automatic longint q_one(input int dw);
    return longint'(1) << (dw - INT_BITS);
  endfunction

  // idx 0..3 = real m00..m11, idx 4..7 = imag m00..m11; GATE_FULL is a full-scale exerciser entry
  function automatic longint rom_comp(input logic [GATE_BITS-1:0] code, input int idx, input int dw);
    longint one, h, mx, zr;
    longint re[4];
    longint im[4];
    zr  = 64'sd0;
    one = q_one(dw);
    h   = (one * 64'sd46341) >>> 16;
    mx  = (longint'(1) << (dw - 1)) - 64'sd1;
    re  = '{one, zr, zr, one};
    im  = '{zr, zr, zr, zr};
    case (code)
      GATE_X:    re = '{zr, one, one, zr};
      GATE_Y: begin
        re = '{zr, zr, zr, zr};
        im = '{zr, -one, one, zr};
      end
      GATE_Z:    re = '{one, zr, zr, -one};
      GATE_H:    re = '{h, h, h, -h};
      GATE_S: begin
        re = '{one, zr, zr, zr};
        im = '{zr, zr, zr, one};
      end
      GATE_T: begin
        re = '{one, zr, zr, h};
        im = '{zr, zr, zr, h};
      end
      GATE_FULL: begin
        re = '{mx, mx, mx, mx};
        im = '{mx, mx, mx, mx};
      end
      default: ;
    endcase
    return idx[2] ? im[idx[1:0]] : re[idx[1:0]];
  endfunction

endpackage

// File: rtl/sequence_multiplier_gate_rom.sv
// rtl/sequence_multiplier_gate_rom.sv - gate code to 2x2 complex matrix, one-cycle registered read
module gate_rom
  import sequence_multiplier_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rd_en_i,
  input  logic [GATE_BITS-1:0]    code_i,
  output logic [4*DATA_WIDTH-1:0] g_re_o,
  output logic [4*DATA_WIDTH-1:0] g_im_o
);

  logic [4*DATA_WIDTH-1:0] g_re_q;
  logic [4*DATA_WIDTH-1:0] g_im_q;

  // Holds the last read so the multiplier sees a stable gate after the accept cycle
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      for (int e = 0; e < 4; e++) begin
        g_re_q[e*DATA_WIDTH +: DATA_WIDTH] <= DATA_WIDTH'(rom_comp(code_i, e, DATA_WIDTH));
        g_im_q[e*DATA_WIDTH +: DATA_WIDTH] <= DATA_WIDTH'(rom_comp(code_i, e + 4, DATA_WIDTH));
      end
    end
  end

  assign g_re_o = g_re_q;
  assign g_im_o = g_im_q;

endmodule

// File: rtl/sequence_multiplier.sv
// rtl/sequence_multiplier.sv - folds the gate stream into a 2x2 complex product with one serial MAC
module sequence_multiplier
  import sequence_multiplier_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEQ_INDEX_BITS-1:0] seq_index,
  input  logic [GATE_BITS-1:0]      seq_gate,
  input  logic                      ready,
  input  logic                      first,
  output logic                      available,
  output logic                      result_valid,
  output logic [4*DATA_WIDTH-1:0]   result_re,
  output logic [4*DATA_WIDTH-1:0]   result_im
);

  localparam int DW    = DATA_WIDTH;
  localparam int ACC_W = 2 * DW + 2;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 2);
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [4*DW-1:0]  IDENT_RE   = {DW'(q_one(DW)), {(2*DW){1'b0}}, DW'(q_one(DW))};
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((longint'(1) << (DW - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  mult_state_e              state_q;
  logic                     available_q, result_valid_q, first_q, last_q;
  logic [CNT_W-1:0]         settle_q;
  logic [2:0]               k_q;
  logic [4*DW-1:0]          acc_re_q, acc_im_q, tmp_re_q, tmp_im_q;
  logic signed [ACC_W-1:0]  sum_re_q, sum_im_q;
  logic [4*DW-1:0]          g_re, g_im;
  logic                     accept_d;
  logic [1:0]               a_idx_d, b_idx_d;
  logic signed [DW-1:0]     ar_d, ai_d, br_d, bi_d;
  logic signed [ACC_W-1:0]  term_re_d, term_im_d, full_re_d, full_im_d;

  function automatic logic [DW-1:0] sat(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> (DW - INT_BITS);
    if (s > SAT_HI) s = SAT_HI;
    else if (s < SAT_LO) s = SAT_LO;
    return s[DW-1:0];
  endfunction

  assign accept_d = (state_q == ST_IDLE) && available_q && (settle_q == SETTLE_MAX) && ready;

  gate_rom #(.DATA_WIDTH(DW)) u_rom (
    .clk     (clk),
    .rd_en_i (accept_d),
    .code_i  (seq_gate),
    .g_re_o  (g_re),
    .g_im_o  (g_im)
  );

  // k = {row, col, term}: term j multiplies acc[row][j] by G[j][col]
  always_comb begin
    a_idx_d   = {k_q[2], k_q[0]};
    b_idx_d   = {k_q[0], k_q[1]};
    ar_d      = acc_re_q[int'(a_idx_d)*DW +: DW];
    ai_d      = acc_im_q[int'(a_idx_d)*DW +: DW];
    br_d      = g_re[int'(b_idx_d)*DW +: DW];
    bi_d      = g_im[int'(b_idx_d)*DW +: DW];
    term_re_d = ACC_W'(ar_d) * ACC_W'(br_d) - ACC_W'(ai_d) * ACC_W'(bi_d);
    term_im_d = ACC_W'(ar_d) * ACC_W'(bi_d) + ACC_W'(ai_d) * ACC_W'(br_d);
    full_re_d = sum_re_q + term_re_d;
    full_im_d = sum_im_q + term_im_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      available_q    <= 1'b0;
      result_valid_q <= 1'b0;
      settle_q       <= '0;
      first_q        <= 1'b0;
      last_q         <= 1'b0;
      k_q            <= '0;
      acc_re_q       <= IDENT_RE;
      acc_im_q       <= '0;
      tmp_re_q       <= '0;
      tmp_im_q       <= '0;
      sum_re_q       <= '0;
      sum_im_q       <= '0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          available_q <= 1'b1;
          if (settle_q < SETTLE_MAX) settle_q <= settle_q + CNT_W'(1);
          if (accept_d) begin
            first_q     <= first;
            last_q      <= (seq_index == '0);
            available_q <= 1'b0;
            settle_q    <= '0;
            state_q     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          k_q <= '0;
          if (first_q) begin
            tmp_re_q <= g_re;
            tmp_im_q <= g_im;
            state_q  <= ST_WRITE;
          end else begin
            state_q  <= ST_MULT;
          end
        end
        ST_MULT: begin
          if (!k_q[0]) begin
            sum_re_q <= term_re_d;
            sum_im_q <= term_im_d;
          end else begin
            tmp_re_q[int'(k_q[2:1])*DW +: DW] <= sat(full_re_d);
            tmp_im_q[int'(k_q[2:1])*DW +: DW] <= sat(full_im_d);
          end
          k_q <= k_q + 3'd1;
          if (k_q == 3'd7) state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          acc_re_q       <= tmp_re_q;
          acc_im_q       <= tmp_im_q;
          result_valid_q <= last_q;
          state_q        <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign available    = available_q;
  assign result_valid = result_valid_q;
  assign result_re    = acc_re_q;
  assign result_im    = acc_im_q;

endmodule
